// File: rtl/mem_preloader_pkg.sv
// rtl/mem_preloader_pkg.sv - shared defaults and state encoding for the memory preloader
package mem_preloader_pkg;

    localparam int REG_WIDTH_DEFAULT = 8;
    localparam int MEM_DEPTH_DEFAULT = 65536;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_VERIFY = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/preload_addr_gen.sv
// rtl/preload_addr_gen.sv - wrapping address and word counter with last-word flag
//
// Ports:
//   clk, reset_n : clock, synchronous active-low reset
//   load, base   : restart the sequence at base with the counter at zero
//   step         : advance one word (ignored when load is high)
//   len          : word count of the current operation
//   addr         : current address, wraps from MEM_DEPTH-1 to 0
//   last         : counter is at len-1
module preload_addr_gen #(
    parameter int MEM_DEPTH  = 65536,
    parameter int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  load,
    input  logic                  step,
    input  logic [ADDR_WIDTH-1:0] base,
    input  logic [ADDR_WIDTH:0]   len,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  last
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = ADDR_WIDTH'(MEM_DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH + 1)'(1);

    logic [ADDR_WIDTH:0] count;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            addr  <= '0;
            count <= '0;
        end else if (load) begin
            addr  <= base;
            count <= '0;
        end else if (step) begin
            addr  <= (addr == ADDR_MAX) ? '0 : addr + ADDR_ONE;
            count <= count + CNT_ONE;
        end
    end

    assign last = (count == len - CNT_ONE);

endmodule

// File: rtl/mem_preloader.sv
// rtl/mem_preloader.sv - streams an image into memory with optional readback checksum verify
//
// Ports:
//   clk, reset_n                 : clock, synchronous active-low reset
//   start, base_addr, length,
//   verify_en                    : load request and its parameters (taken in IDLE only)
//   in_valid, in_data, in_ready  : image word stream
//   mem_wr_en, mem_addr,
//   mem_wr_data, mem_rd_data     : memory port (read data one cycle after address)
//   cpu_hold                     : keeps the CPU off the bus while not idle
//   busy, done, error, checksum  : status; done is a one-cycle pulse, error is sticky
module mem_preloader
    import mem_preloader_pkg::*;
#(
    parameter int REG_WIDTH  = REG_WIDTH_DEFAULT,
    parameter int MEM_DEPTH  = MEM_DEPTH_DEFAULT,
    parameter int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    input  logic                  verify_en,
    input  logic                  in_valid,
    input  logic [REG_WIDTH-1:0]  in_data,
    output logic                  in_ready,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [REG_WIDTH-1:0]  mem_wr_data,
    input  logic [REG_WIDTH-1:0]  mem_rd_data,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [REG_WIDTH-1:0]  checksum
);

    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(MEM_DEPTH);

    state_t state, next_state;

    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH:0]   len_q;
    logic                  verify_q;
    logic [REG_WIDTH-1:0]  rb_sum;
    logic [REG_WIDTH-1:0]  rb_next;
    logic                  rd_pending;

    logic                  gen_load;
    logic                  gen_step;
    logic [ADDR_WIDTH-1:0] gen_base;
    logic [ADDR_WIDTH-1:0] gen_addr;
    logic                  gen_last;

    preload_addr_gen #(
        .MEM_DEPTH  (MEM_DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (gen_load),
        .step    (gen_step),
        .base    (gen_base),
        .len     (len_q),
        .addr    (gen_addr),
        .last    (gen_last)
    );

    assign mem_addr = gen_addr;
    assign rb_next  = rb_sum + mem_rd_data;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        in_ready    = 1'b0;
        mem_wr_en   = 1'b0;
        mem_wr_data = '0;
        gen_load    = 1'b0;
        gen_step    = 1'b0;
        gen_base    = base_q;
        busy        = 1'b0;
        done        = 1'b0;
        cpu_hold    = (state != ST_IDLE);
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    // base_q is captured on this same edge, so seed the generator directly
                    gen_load = 1'b1;
                    gen_base = base_addr;
                    if (length == '0 || length > DEPTH_W) begin
                        next_state = ST_DONE;
                    end else begin
                        next_state = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) begin
                    mem_wr_en   = 1'b1;
                    mem_wr_data = in_data;
                    gen_step    = 1'b1;
                    if (gen_last) begin
                        if (verify_q) begin
                            // rewind to the first word for the readback pass
                            gen_load   = 1'b1;
                            next_state = ST_VERIFY;
                        end else begin
                            next_state = ST_DONE;
                        end
                    end
                end
            end
            ST_VERIFY: begin
                busy     = 1'b1;
                gen_step = 1'b1;
                if (gen_last) begin
                    next_state = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                busy       = 1'b1;
                next_state = ST_DONE;
            end
            ST_DONE: begin
                done       = 1'b1;
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            base_q     <= '0;
            len_q      <= '0;
            verify_q   <= 1'b0;
            checksum   <= '0;
            rb_sum     <= '0;
            rd_pending <= 1'b0;
            error      <= 1'b0;
        end else begin
            // each VERIFY cycle issues a read whose data lands in the following cycle
            rd_pending <= (state == ST_VERIFY);
            if (rd_pending) begin
                rb_sum <= rb_next;
            end
            if (state == ST_IDLE && start) begin
                base_q   <= base_addr;
                len_q    <= length;
                verify_q <= verify_en;
                checksum <= '0;
                rb_sum   <= '0;
                error    <= (length > DEPTH_W);
            end
            if (state == ST_LOAD && in_valid) begin
                checksum <= checksum + in_data;
            end
            // the final read's data is only on mem_rd_data during DRAIN, so fold it in here
            if (state == ST_DRAIN) begin
                error <= (rb_next != checksum);
            end
        end
    end

endmodule

// File: tb/tb_mem_preloader.sv
// tb/tb_mem_preloader.sv - randomized self-checking bench for mem_preloader
module tb_mem_preloader;

    localparam int DEPTH = 65536;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] base_addr = '0;
    logic [16:0] length = '0;
    logic        verify_en = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_ready;
    logic        mem_wr_en;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wr_data;
    logic [7:0]  mem_rd_data;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        error;
    logic [7:0]  checksum;

    mem_preloader dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .base_addr   (base_addr),
        .length      (length),
        .verify_en   (verify_en),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .mem_wr_en   (mem_wr_en),
        .mem_addr    (mem_addr),
        .mem_wr_data (mem_wr_data),
        .mem_rd_data (mem_rd_data),
        .cpu_hold    (cpu_hold),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .checksum    (checksum)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // memory model: registered read, optional single-bit corruption at address 0
    logic [7:0] mem [0:DEPTH-1];
    bit corrupt0 = 0;
    always @(posedge clk) begin
        if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
        mem_rd_data <= mem[mem_addr] ^ ((corrupt0 && mem_addr == 16'd0) ? 8'h01 : 8'h00);
    end

    // observation records
    bit         mon_en = 0;
    logic [15:0] wr_a[$];
    logic [7:0]  wr_d[$];
    logic [15:0] rd_a[$];
    int done_cnt, done_cyc, done_err, done_sum, first_wr_cyc, last_wr_cyc, start_cyc;
    int err_after;
    logic [7:0] words[$];

    always @(negedge clk) begin
        if (mon_en) begin
            if (mem_wr_en) begin
                if (wr_a.size() == 0) first_wr_cyc = cyc;
                wr_a.push_back(mem_addr);
                wr_d.push_back(mem_wr_data);
                last_wr_cyc = cyc;
            end
            if (busy && !in_ready) rd_a.push_back(mem_addr);
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                done_err = int'(error);
                done_sum = int'(checksum);
            end
        end
    end

    task automatic clear_mon();
        wr_a.delete(); wr_d.delete(); rd_a.delete();
        done_cnt = 0; done_cyc = -1; done_err = -1; done_sum = -1;
        first_wr_cyc = -1; last_wr_cyc = -1;
    endtask

    task automatic fill_words(input int n);
        words.delete();
        for (int i = 0; i < n; i++) words.push_back(8'($urandom_range(0, 255)));
    endtask

    // vmode: 0 always valid, 1 alternating, 2 random
    task automatic run_op(input int base, input int len, input bit ver, input int vmode, input bit mid_start);
        int idx = 0;
        int guard = 0;
        int post = 0;
        bit fire;
        bit seen = 0;
        bit mid_done = 0;
        clear_mon();
        mon_en = 1;
        @(posedge clk); #1;
        start = 1; base_addr = 16'(base); length = 17'(len); verify_en = ver;
        in_valid = 0; in_data = 0;
        start_cyc = cyc;
        while (guard < 600 && post < 3) begin
            @(negedge clk);
            fire = in_valid && in_ready;
            if (done) seen = 1;
            if (seen) post++;
            @(posedge clk); #1;
            start = 0;
            if (fire) idx++;
            if (mid_start && idx == 2 && !mid_done) begin
                start = 1; base_addr = 16'h1234; length = 17'd9; verify_en = ~ver;
                mid_done = 1;
            end
            case (vmode)
                0: in_valid = (idx < len);
                1: in_valid = (idx < len) && (guard % 2 == 1);
                default: in_valid = (idx < len) && ($urandom_range(0, 1) == 1);
            endcase
            in_data = (idx < words.size()) ? words[idx] : 8'h00;
            guard++;
        end
        in_valid = 0;
        err_after = int'(error);
        mon_en = 0;
    endtask

    function automatic logic [7:0] model_sum(input int len);
        logic [7:0] s = 0;
        for (int i = 0; i < len; i++) s += words[i];
        return s;
    endfunction

    function automatic bit model_hits_zero(input int base, input int len);
        for (int i = 0; i < len; i++) if ((base + i) % DEPTH == 0) return 1;
        return 0;
    endfunction

    task automatic test_reset();
        reset_n = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({in_ready, mem_wr_en, busy, done, error, cpu_hold} !== 6'b0) begin
            failures++; $display("FAIL reset_flags got=%b want=000000", {in_ready, mem_wr_en, busy, done, error, cpu_hold});
        end
        checks++;
        if ({mem_addr, mem_wr_data, checksum} !== 32'h0) begin
            failures++; $display("FAIL reset_values addr=%h wdata=%h sum=%h want 0", mem_addr, mem_wr_data, checksum);
        end
        @(posedge clk); #1 reset_n = 1;
    endtask

    task automatic test_basic();
        words = '{8'h11, 8'h22, 8'h33, 8'h44};
        run_op(16'h0010, 4, 0, 0, 0);
        checks++;
        if (wr_a.size() != 4) begin
            failures++; $display("FAIL basic_count got=%0d want=4", wr_a.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (wr_a[i] !== 16'(16 + i) || wr_d[i] !== words[i]) begin
                    failures++; $display("FAIL basic_write%0d got=%h/%h want=%h/%h", i, wr_a[i], wr_d[i], 16'(16 + i), words[i]);
                end
            end
        end
        checks++;
        if (done_sum != 'hAA || done_err != 0 || done_cnt != 1) begin
            failures++; $display("FAIL basic_done sum=%h err=%0d cnt=%0d want AA/0/1", done_sum, done_err, done_cnt);
        end
        checks++;
        if (done_cyc != last_wr_cyc + 1 || rd_a.size() != 0) begin
            failures++; $display("FAIL basic_timing done=%0d lastwr=%0d reads=%0d want done=lastwr+1, 0 reads", done_cyc, last_wr_cyc, rd_a.size());
        end
    endtask

    task automatic test_wrap_verify(input bit corrupt);
        int base = DEPTH - 2;
        corrupt0 = corrupt;
        fill_words(4);
        run_op(base, 4, 1, 0, 0);
        corrupt0 = 0;
        checks++;
        if (wr_a.size() != 4 || rd_a.size() != 5) begin
            failures++; $display("FAIL wrap_counts writes=%0d reads+drain=%0d want 4/5", wr_a.size(), rd_a.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (wr_a[i] !== 16'((base + i) % DEPTH) || rd_a[i] !== 16'((base + i) % DEPTH) || wr_d[i] !== words[i]) begin
                    failures++; $display("FAIL wrap_addr%0d wr=%h rd=%h want=%h", i, wr_a[i], rd_a[i], 16'((base + i) % DEPTH));
                end
            end
        end
        checks++;
        if (done_err != int'(corrupt) || done_sum != int'(model_sum(4)) || done_cnt != 1) begin
            failures++; $display("FAIL wrap_done corrupt=%0d err=%0d sum=%h cnt=%0d want err=%0d sum=%h cnt=1",
                                 corrupt, done_err, done_sum, done_cnt, corrupt, model_sum(4));
        end
        checks++;
        if (err_after != int'(corrupt)) begin
            failures++; $display("FAIL wrap_error_sticky got=%0d want=%0d", err_after, corrupt);
        end
    endtask

    task automatic test_zero_and_overflow();
        fill_words(4);
        run_op(16'h0100, 0, 1, 0, 0);
        checks++;
        if (wr_a.size() != 0 || done_cyc != start_cyc + 1 || done_err != 0 || done_cnt != 1) begin
            failures++; $display("FAIL zero_len writes=%0d done=%0d start=%0d err=%0d cnt=%0d want 0/start+1/0/1",
                                 wr_a.size(), done_cyc, start_cyc, done_err, done_cnt);
        end
        run_op(16'h0100, DEPTH + 1, 0, 0, 0);
        checks++;
        if (wr_a.size() != 0 || done_cyc != start_cyc + 1 || done_err != 1 || done_cnt != 1) begin
            failures++; $display("FAIL overflow_len writes=%0d done=%0d start=%0d err=%0d cnt=%0d want 0/start+1/1/1",
                                 wr_a.size(), done_cyc, start_cyc, done_err, done_cnt);
        end
    endtask

    task automatic test_stall_and_start();
        fill_words(5);
        run_op(16'h0200, 5, 0, 1, 1);
        checks++;
        if (wr_a.size() != 5 || last_wr_cyc - first_wr_cyc != 8) begin
            failures++; $display("FAIL stall_count writes=%0d span=%0d want 5/8", wr_a.size(), last_wr_cyc - first_wr_cyc);
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (wr_a[i] !== 16'(16'h0200 + i) || wr_d[i] !== words[i]) begin
                    failures++; $display("FAIL stall_write%0d got=%h/%h want=%h/%h", i, wr_a[i], wr_d[i], 16'(16'h0200 + i), words[i]);
                end
            end
        end
        checks++;
        if (done_cnt != 1 || done_sum != int'(model_sum(5)) || rd_a.size() != 0) begin
            failures++; $display("FAIL stall_done cnt=%0d sum=%h reads=%0d want 1/%h/0", done_cnt, done_sum, rd_a.size(), model_sum(5));
        end
    endtask

    task automatic test_reset_abort();
        int guard = 0;
        fill_words(4);
        clear_mon();
        mon_en = 1;
        @(posedge clk); #1;
        start = 1; base_addr = 16'h0300; length = 17'd4; verify_en = 1;
        @(posedge clk); #1;
        start = 0; in_valid = 1; in_data = words[0];
        while (wr_a.size() < 2 && guard < 20) begin
            @(posedge clk); #1;
            in_data = words[wr_a.size()];
            guard++;
        end
        in_valid = 0; reset_n = 0;
        @(posedge clk); #1 reset_n = 1;
        @(negedge clk);
        checks++;
        if ({in_ready, mem_wr_en, busy, done, error, cpu_hold} !== 6'b0 || mem_addr !== 16'h0 || checksum !== 8'h0) begin
            failures++; $display("FAIL abort_outputs flags=%b addr=%h sum=%h want zeros",
                                 {in_ready, mem_wr_en, busy, done, error, cpu_hold}, mem_addr, checksum);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (wr_a.size() != 2 || done_cnt != 0) begin
            failures++; $display("FAIL abort_no_done writes=%0d done=%0d want 2/0", wr_a.size(), done_cnt);
        end
        mon_en = 0;
        fill_words(4);
        run_op(16'h0300, 4, 1, 0, 0);
        checks++;
        if (wr_a.size() != 4 || done_cnt != 1 || done_err != 0 || done_sum != int'(model_sum(4))) begin
            failures++; $display("FAIL abort_restart writes=%0d cnt=%0d err=%0d sum=%h want 4/1/0/%h",
                                 wr_a.size(), done_cnt, done_err, done_sum, model_sum(4));
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 6; t++) begin
            int base = ($urandom_range(0, 1) == 1) ? DEPTH - 3 : int'($urandom_range(0, DEPTH - 1));
            int len = int'($urandom_range(1, 8));
            bit ver = 1'($urandom_range(0, 1));
            bit cor = 1'($urandom_range(0, 1));
            bit exp_err;
            fill_words(len);
            corrupt0 = cor;
            run_op(base, len, ver, 2, 0);
            corrupt0 = 0;
            exp_err = ver && cor && model_hits_zero(base, len);
            checks++;
            if (wr_a.size() != len || rd_a.size() != (ver ? len + 1 : 0)) begin
                failures++; $display("FAIL rand%0d_counts writes=%0d reads=%0d want %0d/%0d", t, wr_a.size(), rd_a.size(), len, ver ? len + 1 : 0);
            end else begin
                for (int i = 0; i < len; i++) begin
                    checks++;
                    if (wr_a[i] !== 16'((base + i) % DEPTH) || wr_d[i] !== words[i]) begin
                        failures++; $display("FAIL rand%0d_write%0d got=%h/%h want=%h/%h", t, i, wr_a[i], wr_d[i], 16'((base + i) % DEPTH), words[i]);
                    end
                end
            end
            checks++;
            if (done_cnt != 1 || done_err != int'(exp_err) || done_sum != int'(model_sum(len))) begin
                failures++; $display("FAIL rand%0d_done cnt=%0d err=%0d sum=%h want 1/%0d/%h", t, done_cnt, done_err, done_sum, exp_err, model_sum(len));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap_verify(0);
        test_wrap_verify(1);
        test_zero_and_overflow();
        test_stall_and_start();
        test_reset_abort();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_preloader.md
MEM_PRELOADER -- requirements
Module: mem_preloader

Interface
REQ-001 Parameters: REG_WIDTH, default 8, data word width; MEM_DEPTH, default 65536, memory words; ADDR_WIDTH, default $clog2(MEM_DEPTH), address width.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  one-cycle load request, sampled in IDLE only.
REQ-005 base_addr  input  ADDR_WIDTH  first target address, captured on accepted start.
REQ-006 length  input  ADDR_WIDTH+1  word count 0..MEM_DEPTH, captured on accepted start.
REQ-007 verify_en  input  1  run readback checksum after load, captured on accepted start.
REQ-008 in_valid / in_data  input  1 / REG_WIDTH  image word stream from the test environment.
REQ-009 in_ready  output  1  stream accept; a word transfers when in_valid && in_ready.
REQ-010 mem_wr_en  output  1  memory write strobe.
REQ-011 mem_addr  output  ADDR_WIDTH  memory address for write or read.
REQ-012 mem_wr_data  output  REG_WIDTH  memory write data.
REQ-013 mem_rd_data  input  REG_WIDTH  memory read data, valid one cycle after mem_addr is presented with mem_wr_en=0.
REQ-014 cpu_hold  output  1  holds CPU off the memory bus; high whenever state != IDLE.
REQ-015 busy / done / error  output  1 each  in operation / one-cycle completion pulse / sticky failure flag.
REQ-016 checksum  output  REG_WIDTH  modulo-2^REG_WIDTH sum of words written by the last load.

Function
REQ-017 States: IDLE, LOAD, VERIFY, DRAIN, DONE.
REQ-018 IDLE: start=1 captures base_addr, length, verify_en; clears checksum, readback sum, word counter and error.
REQ-019 IDLE transitions: length=0 goes to DONE; length>MEM_DEPTH sets error and goes to DONE; otherwise goes to LOAD.
REQ-020 LOAD: in_ready=1; each transfer drives mem_wr_en=1, mem_addr=current address, mem_wr_data=in_data combinationally in the same cycle, and adds in_data to checksum.
REQ-021 LOAD: in_valid=0 stalls with no write; address and counter hold.
REQ-022 Address advances +1 per transfer and wraps from MEM_DEPTH-1 to 0.
REQ-023 Last transfer (counter = length-1): next state is VERIFY if verify_en, else DONE.
REQ-024 VERIFY: in_ready=0, mem_wr_en=0; issues one read per cycle starting at base_addr with the same wrap rule, length reads total, no gaps.
REQ-025 Readback data arrives one cycle after each read and is added to the readback sum.
REQ-026 After the last read is issued, go to DRAIN for exactly one cycle to capture the final data, then DONE.
REQ-027 On entry to DONE from DRAIN: error=1 if readback sum != checksum.
REQ-028 DONE: done=1 for exactly one cycle, then IDLE; error holds until the next accepted start or reset.
REQ-029 start outside IDLE is ignored; it has no effect on state or captured values.
REQ-030 busy=1 in LOAD, VERIFY and DRAIN; cpu_hold=1 in every state except IDLE.
REQ-031 in_ready=0 and mem_wr_en=0 in every state except LOAD.

Reset
REQ-032 reset_n=0 at a clock edge: state=IDLE; in_ready, mem_wr_en, busy, done, error, cpu_hold=0; mem_addr, mem_wr_data, checksum, counters=0.
REQ-033 Reset mid-LOAD or mid-VERIFY aborts immediately; no further writes; no done pulse.

Structure
REQ-034 Shared package holds REG_WIDTH and MEM_DEPTH defaults and the state enum typedef.
REQ-035 One sub-module, preload_addr_gen: address/counter generator with wrap and last flag, reused by LOAD and VERIFY.

Verification
REQ-036 base=0x0010, length=4, verify_en=0, words 0x11,0x22,0x33,0x44 back-to-back -> writes to 0x10..0x13; checksum=0xAA; done pulse 1 cycle after the last write; error=0.
REQ-037 base=MEM_DEPTH-2, length=4, verify_en=1, ideal memory -> writes to MEM_DEPTH-2, MEM_DEPTH-1, 0, 1; reads in the same order; DRAIN observed; error=0.
REQ-038 Same as REQ-037 but the memory model corrupts address 0 (returns data XOR 0x01) -> error=1 at done; checksum unchanged.
REQ-039 length=0 -> done 1 cycle after start, no mem_wr_en; length=MEM_DEPTH+1 -> error=1, done, no writes.
REQ-040 in_valid toggled 1-0-1-0 during LOAD, plus start pulsed mid-LOAD -> writes only on valid cycles; start ignored; final addresses correct.
REQ-041 reset_n=0 after 2 of 4 writes -> outputs at reset values next cycle; no done; a new start then completes normally.
